call_stack_controller: RTL and testbench

CALL_STACK_CONTROLLER -- requirements
Module: call_stack_controller

---
 rtl/call_stack_controller.sv | 161 ++++++++++++++++
 tb/tb_call_stack_controller.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/call_stack_controller.sv
// Call-stack sequencer for hardware function modules: dispatches one function at a time,
// saves caller frames on non-tail calls and restores them when the callee returns.
module call_stack_controller #(
  parameter int NUM_FUNC = 10,
  parameter int ARITY    = 2,
  parameter int DATA_W   = 32,
  parameter int FRAME_W  = 7,
  parameter int DEPTH    = 64
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           run_start,
  input  logic [31:0]                                    run_func,
  input  logic [ARITY-1:0][DATA_W-1:0]                   run_args,
  output logic                                           busy,
  output logic                                           done,
  output logic [DATA_W-1:0]                              result,
  output logic                                           err,
  output logic [NUM_FUNC-1:0]                            start,
  output logic [ARITY-1:0][DATA_W-1:0]                   args,
  output logic [DATA_W-1:0]                              get,
  output logic [FRAME_W-1:0][DATA_W-1:0]                 restore,
  input  logic [NUM_FUNC-1:0]                            endOfFunc,
  input  logic [NUM_FUNC-1:0]                            nontailCall,
  input  logic [NUM_FUNC-1:0][ARITY-1:0][DATA_W-1:0]     call_args,
  input  logic [NUM_FUNC-1:0][DATA_W-1:0]                ret,
  input  logic [NUM_FUNC-1:0][31:0]                      func,
  input  logic [NUM_FUNC-1:0][FRAME_W-1:0][DATA_W-1:0]   save,
  // Debug view: 0 IDLE, 1 DISPATCH, 2 RUN, 3 PUSH, 4 POP, 5 FINISH, 6 ERROR
  output logic [2:0]                                     dbg_state,
  output logic [$clog2(DEPTH+1)-1:0]                     dbg_sp
);

  localparam int FID_W   = (NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1;
  localparam int SP_W    = $clog2(DEPTH + 1);
  localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FRAME_B = FRAME_W * DATA_W;
  localparam int ENTRY_W = 32 + FRAME_B;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DISPATCH = 3'd1,
    RUN      = 3'd2,
    PUSH     = 3'd3,
    POP      = 3'd4,
    FINISH   = 3'd5,
    ERROR    = 3'd6
  } state_t;

  state_t                     state, next;
  logic [FID_W-1:0]           cur_func, callee;
  logic [ARITY-1:0][DATA_W-1:0] pend_args;
  logic [SP_W-1:0]            sp, sp_m1;
  logic [ENTRY_W-1:0]         mem [DEPTH];
  logic [ENTRY_W-1:0]         rd_entry, wdata;
  logic [ADDR_W-1:0]          addr;
  logic                       we, re;
  logic                       eof, ntc, run_bad, callee_bad, overflow, pop_bad;
  logic [31:0]                pop_func;

  always_comb begin
    eof        = endOfFunc[cur_func];
    ntc        = nontailCall[cur_func];
    run_bad    = run_func >= 32'(NUM_FUNC);
    callee_bad = func[cur_func] >= 32'(NUM_FUNC);
    overflow   = sp == SP_W'(DEPTH);
    sp_m1      = sp - SP_W'(1);
    pop_func   = rd_entry[ENTRY_W-1 -: 32];
    // A popped ID outside the legal range can only come from a corrupted stack entry
    pop_bad    = pop_func >= 32'(NUM_FUNC);
    we         = (state == PUSH);
    re         = (state == RUN) && eof && !ntc && (sp != '0);
    addr       = we ? ADDR_W'(sp) : ADDR_W'(sp_m1);
    wdata      = {32'(cur_func), save[cur_func]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:     if (run_start) next = run_bad ? ERROR : DISPATCH;
      DISPATCH: next = RUN;
      RUN: begin
        if (eof && ntc)                   next = ERROR;
        else if (ntc)                     next = (overflow || callee_bad) ? ERROR : PUSH;
        else if (eof)                     next = (sp != '0) ? POP : FINISH;
      end
      PUSH:     next = DISPATCH;
      POP:      next = pop_bad ? ERROR : DISPATCH;
      FINISH:   next = IDLE;
      ERROR:    next = ERROR;
      default:  next = ERROR;
    endcase
  end

  always_comb begin
    start     = (state == DISPATCH) ? (NUM_FUNC'(1) << cur_func) : '0;
    busy      = (state == DISPATCH) || (state == RUN) || (state == PUSH) ||
                (state == POP) || (state == FINISH);
    done      = (state == FINISH);
    err       = (state == ERROR);
    dbg_state = state;
    dbg_sp    = sp;
  end

  // Single-port stack RAM; a read is launched on the RUN->POP edge so data is ready in POP
  always_ff @(posedge clk) begin
    if (we)      mem[addr] <= wdata;
    else if (re) rd_entry  <= mem[addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_func  <= '0;
      callee    <= '0;
      pend_args <= '0;
      args      <= '0;
      get       <= '0;
      restore   <= '0;
      result    <= '0;
      sp        <= '0;
    end else begin
      unique case (state)
        IDLE: if (run_start && !run_bad) begin
          cur_func <= FID_W'(run_func);
          args     <= run_args;
          restore  <= '0;
        end
        RUN: begin
          if (ntc && !eof && !overflow && !callee_bad) begin
            pend_args <= call_args[cur_func];
            callee    <= FID_W'(func[cur_func]);
          end else if (eof && !ntc) begin
            if (sp != '0) begin
              get <= ret[cur_func];
              sp  <= sp_m1;
            end else begin
              result <= ret[cur_func];
            end
          end
        end
        PUSH: begin
          sp       <= sp + SP_W'(1);
          cur_func <= callee;
          args     <= pend_args;
          restore  <= '0;
        end
        POP: if (!pop_bad) begin
          cur_func <= FID_W'(pop_func);
          restore  <= rd_entry[FRAME_B-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_call_stack_controller.sv
// Bench for call_stack_controller: a recursive factorial function module is emulated
// at function level, results go through a scoreboard queue checked by a monitor.
module tb_call_stack_controller;
  localparam int NF = 10, AR = 2, DW = 32, FW = 7, DP = 4;
  localparam int SPW = $clog2(DP + 1);
  localparam int FACT = 1, RESUME_PC = 4;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_RUN = 3'd2, ST_ERROR = 3'd6;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                              run_start = 1'b0;
  logic [31:0]                       run_func = '0;
  logic [AR-1:0][DW-1:0]             run_args = '0;
  logic                              busy, done, err;
  logic [DW-1:0]                     result, get;
  logic [NF-1:0]                     start;
  logic [AR-1:0][DW-1:0]             args;
  logic [FW-1:0][DW-1:0]             restore;
  logic [NF-1:0]                     endOfFunc, nontailCall;
  logic [NF-1:0][AR-1:0][DW-1:0]     call_args;
  logic [NF-1:0][DW-1:0]             ret;
  logic [NF-1:0][31:0]               func;
  logic [NF-1:0][FW-1:0][DW-1:0]     save;
  logic [2:0]                        dbg_state;
  logic [SPW-1:0]                    dbg_sp;

  call_stack_controller #(.NUM_FUNC(NF), .ARITY(AR), .DATA_W(DW), .FRAME_W(FW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .run_start(run_start), .run_func(run_func), .run_args(run_args),
    .busy(busy), .done(done), .result(result), .err(err), .start(start), .args(args),
    .get(get), .restore(restore), .endOfFunc(endOfFunc), .nontailCall(nontailCall),
    .call_args(call_args), .ret(ret), .func(func), .save(save),
    .dbg_state(dbg_state), .dbg_sp(dbg_sp)
  );

  int checks = 0, errors = 0;
  int epoch = 0, done_count = 0, start_count = 0, pushes = 0, pops = 0;
  logic [DW-1:0] exp_q[$];
  logic stray_en = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fact_ref(input int n);
    logic [DW-1:0] r = 1;
    for (int i = 2; i <= n; i++) r = r * DW'(i);
    return r;
  endfunction

  // function-module outputs: index FACT is the modelled function, the rest hold junk
  logic                   m_eof = 1'b0, m_ntc = 1'b0;
  logic [DW-1:0]          m_ret = '0;
  logic [FW-1:0][DW-1:0]  m_save = '0;
  logic [AR-1:0][DW-1:0]  m_call_args = '0;
  logic [NF-1:0]          eof_stray = '0, nc_stray = '0;

  always_comb begin
    endOfFunc   = eof_stray;
    nontailCall = nc_stray;
    for (int i = 0; i < NF; i++) begin
      ret[i]       = 32'hbad0_0000 + 32'(i);
      func[i]      = 32'(i + 3);
      call_args[i] = {AR{32'h5a5a_0000 + 32'(i)}};
      save[i]      = {FW{32'hc0de_0000 + 32'(i)}};
    end
    endOfFunc[FACT]   = m_eof;
    nontailCall[FACT] = m_ntc;
    ret[FACT]         = m_ret;
    func[FACT]        = 32'(FACT);
    call_args[FACT]   = m_call_args;
    save[FACT]        = m_save;
  end

  // Factorial function module: fact(n) = n<=1 ? 1 : n * fact(n-1), frame = {pc, n, junk}
  logic [FW-1:0][DW-1:0] frames[$];
  logic [DW-1:0] last_ret = '0;
  always begin : fact_model
    int seen_epoch, my_epoch, k;
    logic [DW-1:0] n, resp_ret, exp_arg;
    logic resp_eof, resp_ntc, arg_pending;
    logic [FW-1:0][DW-1:0] fr, exp_fr;
    logic [AR-1:0][DW-1:0] resp_args;
    @(negedge clk);
    if (!rst && start[FACT]) begin
      if (seen_epoch != epoch) begin
        frames.delete();
        arg_pending = 1'b0;
        seen_epoch = epoch;
      end
      my_epoch = epoch;
      resp_eof = 1'b0; resp_ntc = 1'b0; resp_ret = '0; resp_args = '0; fr = '0;
      if (restore == '0) begin
        n = args[0];
        if (arg_pending) check("callee_arg", args[0], exp_arg);
        arg_pending = 1'b0;
        if (n <= 1) begin
          resp_eof = 1'b1;
          resp_ret = 1;
        end else begin
          resp_ntc = 1'b1;
          for (int w = 0; w < FW; w++) fr[w] = $urandom;
          fr[0] = RESUME_PC;
          fr[1] = n;
          frames.push_back(fr);
          pushes++;
          resp_args[0] = n - 1;
          resp_args[1] = $urandom;
          exp_arg = n - 1;
          arg_pending = 1'b1;
        end
      end else begin
        pops++;
        exp_fr = '0;
        if (frames.size() == 0) begin
          checks++; errors++;
          $display("FAIL resume_without_frame actual=%0h expected=empty_stack_no_resume", restore);
        end else exp_fr = frames.pop_back();
        check("resume_pc", restore[0], RESUME_PC);
        check("resume_frame", restore, exp_fr);
        check("resume_get", get, last_ret);
        resp_eof = 1'b1;
        resp_ret = restore[1] * get;
      end
      k = $urandom_range(1, 3);
      repeat (k) @(negedge clk);
      if (my_epoch == epoch && !rst) begin
        m_eof = resp_eof; m_ntc = resp_ntc; m_ret = resp_ret;
        m_call_args = resp_args;
        if (resp_ntc) m_save = fr;
        if (resp_eof) last_ret = resp_ret;
        @(negedge clk);
        m_eof = 1'b0; m_ntc = 1'b0;
      end
    end
  end

  // Stray flags on indices that are never the current function
  always begin : stray
    int idx, kind;
    @(negedge clk);
    eof_stray = '0; nc_stray = '0;
    if (stray_en && $urandom_range(0, 4) == 0) begin
      idx = $urandom_range(0, NF - 2);
      if (idx >= FACT) idx++;
      kind = $urandom_range(0, 2);
      if (kind != 1) eof_stray[idx] = 1'b1;
      if (kind != 0) nc_stray[idx] = 1'b1;
    end
  end

  // Monitor / scoreboard
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (start != '0) begin
        start_count++;
        check("start_onehot", start, NF'(1) << FACT);
      end
      if (done) begin
        done_count++;
        check("done_single_cycle", prev_done, 1'b0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=%0h expected=no_done", result);
        end else check("result", result, exp_q.pop_front());
      end
    end
    prev_done = done;
  end

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    epoch++;
    exp_q.delete();
    run_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(input logic [31:0] fid, input int n, input bit expect_done);
    @(negedge clk);
    run_start = 1'b1;
    run_func = fid;
    run_args[0] = DW'(n);
    run_args[1] = $urandom;
    if (expect_done) exp_q.push_back(fact_ref(n));
    @(negedge clk);
    run_start = 1'b0;
  endtask

  task automatic wait_done(input bit pokes, output int peak);
    int d0, cyc;
    d0 = done_count; cyc = 0; peak = 0;
    while (done_count == d0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (int'(dbg_sp) > peak) peak = int'(dbg_sp);
      if (pokes && busy && $urandom_range(0, 3) == 0) begin
        run_start = 1'b1;
        run_func = $urandom_range(0, NF + 2);
        run_args = {$urandom, $urandom};
      end else run_start = 1'b0;
    end
    run_start = 1'b0;
    if (done_count == d0) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=no_done expected=done_within_2000_cycles");
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_args"}, args, 0);
    check({tag, "_get"}, get, 0);
    check({tag, "_restore"}, restore, 0);
    check({tag, "_sp"}, dbg_sp, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin : main
    int peak, s0, p0, q0, cyc, n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_cleared("reset");

    // fact(1): single dispatch, no stack use
    s0 = start_count;
    issue(FACT, 1, 1'b1);
    wait_done(1'b0, peak);
    check("fact1_starts", start_count - s0, 1);
    check("fact1_peak_sp", peak, 0);

    // fact(5): four pushes and four pops, stack fills exactly
    s0 = start_count; p0 = pushes; q0 = pops;
    issue(FACT, 5, 1'b1);
    wait_done(1'b0, peak);
    check("fact5_pushes", pushes - p0, 4);
    check("fact5_pops", pops - q0, 4);
    check("fact5_peak_sp", peak, 4);
    check("fact5_starts", start_count - s0, 9);
    @(negedge clk);
    check("fact5_idle_busy", busy, 0);
    check("fact5_sp_back", dbg_sp, 0);

    // random runs with stray flags and run_start pokes while busy
    stray_en = 1'b1;
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(0, 5);
      issue(FACT, n, 1'b1);
      wait_done(1'b1, peak);
    end

    // reset while sp=3 in RUN, then a fresh run
    issue(FACT, 5, 1'b1);
    cyc = 0;
    while (!(dbg_sp == 3 && dbg_state == ST_RUN) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_sp3_run", (dbg_sp == 3 && dbg_state == ST_RUN), 1);
    rst = 1'b1;
    epoch++;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check_cleared("midrun_reset");
    issue(FACT, 3, 1'b1);
    wait_done(1'b1, peak);
    stray_en = 1'b0;

    // overflow: fact(10) on a 4-deep stack
    do_reset();
    p0 = pushes;
    issue(FACT, 10, 1'b0);
    cyc = 0;
    while (!err && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("ovf_err", err, 1);
    check("ovf_sp", dbg_sp, DP);
    check("ovf_busy", busy, 0);
    check("ovf_state", dbg_state, ST_ERROR);
    check("ovf_calls", pushes - p0, 5);
    s0 = start_count;
    q0 = done_count;
    issue(FACT, 2, 1'b0);
    repeat (20) @(negedge clk);
    check("ovf_no_starts", start_count - s0, 0);
    check("ovf_no_done", done_count - q0, 0);
    check("ovf_err_sticky", err, 1);

    // illegal entry function ID
    do_reset();
    s0 = start_count;
    issue(NF, 2, 1'b0);
    repeat (5) @(negedge clk);
    check("badid_err", err, 1);
    check("badid_state", dbg_state, ST_ERROR);
    check("badid_busy", busy, 0);
    check("badid_no_start", start_count - s0, 0);

    do_reset();
    check("final_err_cleared", err, 0);
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog actual=still_running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
